// File: rtl/dmem_pkg.sv
// Shared types and sizes for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing one async-read DataMemory among
// NUM_REQ requesters, with a registered one-cycle write strobe.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = DMEM_ADDR_W,
    parameter int unsigned DATA_W  = DMEM_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_write_enable,
    input  logic [DATA_W-1:0]         mem_read_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    dmem_state_t      state;
    dmem_state_t      state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic             op_we;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Ready is offered only while idle and out of reset, so no grant leaks during reset.
    assign req_ready = (rst_n && (state == IDLE)) ? grant : '0;
    assign accept_c  = (state == IDLE) && grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept_c) state_nxt = SETUP;
            SETUP:   state_nxt = op_we ? STROBE : RESP;
            STROBE:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up exactly with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr           <= '0;
            owner            <= '0;
            op_we            <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            rsp_valid        <= '0;
            rsp_rdata        <= '0;
            busy             <= 1'b0;
        end else begin
            busy             <= (state_nxt != IDLE);
            mem_write_enable <= (state_nxt == STROBE);
            rsp_valid        <= (state_nxt == RESP) ? (NUM_REQ'(1) << owner) : '0;
            if (accept_c) begin
                rr_ptr         <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                owner          <= grant_idx;
                op_we          <= req_we[grant_idx];
                mem_address    <= req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
                mem_write_data <= req_wdata[32'(grant_idx) * DATA_W +: DATA_W];
            end
            if ((state == SETUP) && !op_we) begin
                rsp_rdata <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter with a DataMemory stand-in and
// a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned AW      = 8;
    localparam int unsigned DW      = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_we;
    logic [NUM_REQ*AW-1:0]  req_addr;
    logic [NUM_REQ*DW-1:0]  req_wdata;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [DW-1:0]          rsp_rdata;
    logic                   busy;
    logic [AW-1:0]          mem_address;
    logic [DW-1:0]          mem_write_data;
    logic                   mem_write_enable;
    logic [DW-1:0]          mem_read_data;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .busy             (busy),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // DataMemory: async read, write on rising edge of write_enable
    logic [DW-1:0] dmem [256];
    always @(posedge mem_write_enable) dmem[mem_address] <= mem_write_data;
    assign mem_read_data = dmem[mem_address];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: memory image, in-flight transaction and its age in cycles
    logic [DW-1:0] ref_mem [256];
    int            m_k, m_owner, m_ptr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rdata;

    // requester drivers and observations
    logic [NUM_REQ-1:0] pend;
    logic               q_we   [NUM_REQ];
    logic [AW-1:0]      q_addr [NUM_REQ];
    logic [DW-1:0]      q_data [NUM_REQ];
    int                 burst  [NUM_REQ];
    bit                 rand_en;
    int                 rsp_cnt [NUM_REQ];
    int                 lat     [NUM_REQ];
    int                 hs_cyc  [NUM_REQ];
    logic [DW-1:0]      rdata_obs [NUM_REQ];
    int                 we_cnt, busy_cnt;
    int                 grants [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int first_from(input logic [NUM_REQ-1:0] v, input int p);
        for (int o = 0; o < NUM_REQ; o++) begin
            if (v[(p + o) % NUM_REQ]) return (p + o) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(3))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return AW'($urandom_range(7));
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_k = 0; m_owner = 0; m_ptr = 0; m_we = 1'b0;
        m_addr = '0; m_data = '0; m_rdata = '0;
    endtask

    task automatic post(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        q_we[i] = we; q_addr[i] = a; q_data[i] = d; pend[i] = 1'b1;
    endtask

    task automatic wait_quiet(input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while ((pend != '0 || m_k != 0 || burst[0] != 0 || burst[1] != 0) && n < 400);
        chk({nm, " timeout"}, 32'(n >= 400), 32'd0);
        @(posedge clk);
    endtask

    // per-cycle compare, drive and model step (mid-cycle, away from the active edge)
    always @(negedge clk) begin
        int g;
        int len;
        logic [NUM_REQ-1:0] exp_rsp, exp_rdy, hs;
        cyc++;
        if (!rst_n) begin
            model_reset();
            pend = '0;
        end
        len     = m_we ? 3 : 2;
        exp_rsp = (m_k != 0 && m_k == len) ? (NUM_REQ'(1) << m_owner) : '0;
        chk("busy",           32'(busy),             32'(m_k != 0));
        chk("strobe",         32'(mem_write_enable), 32'(m_we && m_k == 2));
        chk("rsp_valid",      32'(rsp_valid),        32'(exp_rsp));
        chk("rsp_rdata",      rsp_rdata,             m_rdata);
        chk("mem_address",    32'(mem_address),      32'(m_addr));
        chk("mem_write_data", mem_write_data,        m_data);
        if (mem_write_enable) we_cnt++;
        if (busy) busy_cnt++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
                lat[i]       = cyc - hs_cyc[i];
                rdata_obs[i] = rsp_rdata;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n) begin
                if (pend[i] && rand_en && $urandom_range(15) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && burst[i] > 0) begin
                    q_we[i] = 1'b0; q_addr[i] = pick_addr(); q_data[i] = $urandom;
                    pend[i] = 1'b1; burst[i]--;
                end else if (!pend[i] && rand_en && $urandom_range(2) == 0) begin
                    q_we[i] = 1'($urandom_range(1)); q_addr[i] = pick_addr(); q_data[i] = $urandom;
                    pend[i] = 1'b1;
                end
            end
            req_valid[i]            = pend[i];
            req_we[i]               = q_we[i];
            req_addr[i*AW +: AW]    = q_addr[i];
            req_wdata[i*DW +: DW]   = q_data[i];
        end
        #1;
        exp_rdy = '0;
        g = (rst_n && m_k == 0) ? first_from(req_valid, m_ptr) : -1;
        if (g >= 0) exp_rdy = NUM_REQ'(1) << g;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        hs = req_valid & req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                hs_cyc[i] = cyc;
                grants.push_back(i);
            end
        end
        if (rst_n) begin
            if (m_k == 0) begin
                if (g >= 0) begin
                    m_k = 1; m_owner = g; m_we = q_we[g]; m_addr = q_addr[g]; m_data = q_data[g];
                    m_ptr = (g + 1) % NUM_REQ;
                    pend[g] = 1'b0;
                end
            end else begin
                m_k++;
                if (m_k > len) m_k = 0;
                else if (m_k == 2) begin
                    if (m_we) ref_mem[m_addr] = m_data;
                    else      m_rdata = ref_mem[m_addr];
                end
            end
        end
    end

    initial begin
        int g0, c0, b0, r0, r1, n;
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        pend = '0; rand_en = 1'b0; we_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            q_we[i] = 1'b0; q_addr[i] = '0; q_data[i] = '0; burst[i] = 0;
            rsp_cnt[i] = 0; lat[i] = 0; hs_cyc[i] = 0; rdata_obs[i] = '0;
        end
        for (int a = 0; a < 256; a++) begin
            dmem[a] <= '0;
            ref_mem[a] = '0;
        end
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        chk("reset busy",      32'(busy),             32'd0);
        chk("reset strobe",    32'(mem_write_enable), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid),        32'd0);
        chk("reset ready",     32'(req_ready),        32'd0);
        chk("reset address",   32'(mem_address),      32'd0);
        chk("reset rdata",     rsp_rdata,             32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        // single write
        c0 = we_cnt;
        post(0, 1'b1, 8'h0A, 32'hABCDEFF0);
        wait_quiet("t1");
        chk("t1 strobe cycles", 32'(we_cnt - c0), 32'd1);
        chk("t1 write latency", 32'(lat[0]), 32'd3);
        chk("t1 mem[0x0A]",     dmem[8'h0A], 32'hABCDEFF0);

        // read-back by the other requester
        post(1, 1'b0, 8'h0A, $urandom);
        wait_quiet("t2");
        chk("t2 read latency", 32'(lat[1]), 32'd2);
        chk("t2 read data",    rdata_obs[1], 32'hABCDEFF0);

        // contention: both held valid, eight reads each
        g0 = grants.size(); r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
        burst[0] = 8; burst[1] = 8;
        wait_quiet("t3");
        chk("t3 grant count", 32'(grants.size() - g0), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (g0 + k < grants.size()) chk("t3 grant order", 32'(grants[g0 + k]), 32'(k % 2));
        end
        chk("t3 rsp count 0", 32'(rsp_cnt[0] - r0), 32'd8);
        chk("t3 rsp count 1", 32'(rsp_cnt[1] - r1), 32'd8);

        // address boundaries
        post(0, 1'b1, 8'hFF, 32'h12345678); wait_quiet("t4a");
        post(1, 1'b1, 8'h00, 32'hDEADBEEF); wait_quiet("t4b");
        post(0, 1'b0, 8'hFF, $urandom);     wait_quiet("t4c");
        chk("t4 read 0xFF", rdata_obs[0], 32'h12345678);
        post(1, 1'b0, 8'h00, $urandom);     wait_quiet("t4d");
        chk("t4 read 0x00", rdata_obs[1], 32'hDEADBEEF);

        // reset while the strobe is high: write already committed, no response
        r0 = rsp_cnt[0];
        post(0, 1'b1, 8'h33, 32'h55AA55AA);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!mem_write_enable && n < 20);
        chk("t5 strobe seen", 32'(mem_write_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5 strobe dropped", 32'(mem_write_enable), 32'd0);
        chk("t5 busy cleared",   32'(busy),             32'd0);
        chk("t5 rsp_valid",      32'(rsp_valid),        32'd0);
        chk("t5 address",        32'(mem_address),      32'd0);
        chk("t5 rdata",          rsp_rdata,             32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        chk("t5 no response", 32'(rsp_cnt[0] - r0), 32'd0);
        chk("t5 committed",   dmem[8'h33], 32'h55AA55AA);

        // reset during setup: write discarded
        post(1, 1'b1, 8'h44, 32'h11112222);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!busy && n < 20);
        chk("t5 setup seen", 32'(busy && !mem_write_enable), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        chk("t5 discarded", dmem[8'h44], 32'd0);
        post(1, 1'b0, 8'h33, $urandom);
        wait_quiet("t5 after reset");
        chk("t5 read after reset", rdata_obs[1], 32'h55AA55AA);
        chk("t5 read latency",     32'(lat[1]), 32'd2);

        // idle: pointer left at 1 must survive
        post(0, 1'b0, 8'h0A, $urandom);
        wait_quiet("t6 prep");
        c0 = we_cnt; b0 = busy_cnt;
        repeat (20) @(posedge clk);
        chk("t6 idle strobe", 32'(we_cnt - c0),   32'd0);
        chk("t6 idle busy",   32'(busy_cnt - b0), 32'd0);
        g0 = grants.size();
        post(0, 1'b0, 8'hFF, $urandom);
        post(1, 1'b0, 8'h00, $urandom);
        wait_quiet("t6");
        chk("t6 grant count", 32'(grants.size() - g0), 32'd2);
        if (g0 + 1 < grants.size()) begin
            chk("t6 first grant",  32'(grants[g0]),     32'd1);
            chk("t6 second grant", 32'(grants[g0 + 1]), 32'd0);
        end

        // randomized traffic against the model
        rand_en = 1'b1;
        repeat (3000) @(posedge clk);
        rand_en = 1'b0;
        wait_quiet("random drain");
        n = 0;
        for (int a = 0; a < 256; a++) begin
            if (dmem[a] !== ref_mem[a]) n++;
        end
        chk("memory image mismatches", 32'(n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
